// File: rtl/text_console_pkg.sv
// Shared constants, state encoding and sizing helper for the text console buffer.
package text_console_pkg;

  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] BS        = 8'h08;
  localparam logic [7:0] FF        = 8'h0C;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SCROLL
  } state_e;

  // Address width for a cell store; never below one bit.
  function automatic int unsigned addr_width(input int unsigned cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character store: one synchronous write port, one registered read port.
module text_ram #(
  parameter int unsigned DEPTH = 4800,
  parameter int unsigned AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // No reset on the array or read register so this maps onto block RAM;
  // a same-address read sees the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_console_buffer.sv
// Character-cell console: byte-stream interpreter with cursor, circular-row scrolling
// and a registered character lookup for the renderer.
module text_console_buffer
  import text_console_pkg::*;
#(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 60,
  parameter int unsigned CELL_W_LOG2 = 3,
  parameter int unsigned CELL_H_LOG2 = 3,
  parameter int unsigned COORD_W     = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic [COORD_W-1:0]      x,
  input  logic [COORD_W-1:0]      y,
  output logic [7:0]              char,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    busy
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = addr_width(CELLS);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned RW    = $clog2(ROWS);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RW-1:0]   top_row_q, top_row_d;
  logic            rd_valid_q, rd_oob_q;

  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [7:0]      ram_wdata;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      ram_rdata;
  logic            advance;
  logic [RW-1:0]   bottom_phys;

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow,
                                              input logic [CW-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  // Logical row to physical row under the current circular offset.
  function automatic logic [RW-1:0] to_phys(input logic [RW-1:0] lrow,
                                            input logic [RW-1:0] top);
    logic [RW:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= (RW+1)'(ROWS)) begin
      sum = sum - (RW+1)'(ROWS);
    end
    return sum[RW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] col_r, row_r;
  logic               rd_oob;

  always_comb begin
    col_r  = x >> CELL_W_LOG2;
    row_r  = y >> CELL_H_LOG2;
    rd_oob = (32'(col_r) >= COLS) || (32'(row_r) >= ROWS);
    if (rd_oob) begin
      rd_addr = '0;
    end else begin
      rd_addr = cell_addr(to_phys(row_r[RW-1:0], top_row_q), col_r[CW-1:0]);
    end
  end

  // Until the first post-reset read lands the RAM output is meaningless, so show a blank.
  assign char = (rd_valid_q && !rd_oob_q) ? ram_rdata : SPACE;

  // ---------------------------------------------------------------------------
  // Control FSM and write path
  // ---------------------------------------------------------------------------
  // The row being scrubbed after a scroll is the one that just left the top.
  assign bottom_phys = (top_row_q == '0) ? RW'(ROWS - 1) : top_row_q - 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    top_row_d = top_row_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = SPACE;
    advance   = 1'b0;

    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == AW'(CELLS - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      SCROLL: begin
        ram_we    = 1'b1;
        ram_waddr = cell_addr(bottom_phys, cnt_q[CW-1:0]);
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == AW'(COLS - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (data_valid) begin
          if (data_in >= SPACE && data_in <= PRINT_MAX) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(to_phys(row_q, top_row_q), col_q);
            ram_wdata = data_in;
            if (col_q == CW'(COLS - 1)) begin
              col_d   = '0;
              advance = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (data_in)
              LF: begin
                col_d   = '0;
                advance = 1'b1;
              end
              CR: col_d = '0;
              BS: begin
                // Backspace never wraps onto the previous line.
                if (col_q != '0) begin
                  col_d     = col_q - 1'b1;
                  ram_we    = 1'b1;
                  ram_waddr = cell_addr(to_phys(row_q, top_row_q), col_q - 1'b1);
                end
              end
              FF: begin
                col_d     = '0;
                row_d     = '0;
                top_row_d = '0;
                cnt_d     = '0;
                state_d   = CLEAR;
              end
              default: ;
            endcase
          end

          if (advance) begin
            if (row_q != RW'(ROWS - 1)) begin
              row_d = row_q + 1'b1;
            end else begin
              top_row_d = (top_row_q == RW'(ROWS - 1)) ? '0 : top_row_q + 1'b1;
              cnt_d     = '0;
              state_d   = SCROLL;
            end
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      top_row_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      top_row_q  <= top_row_d;
      rd_valid_q <= 1'b1;
      rd_oob_q   <= rd_oob;
    end
  end

  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  text_ram #(
    .DEPTH(CELLS),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

endmodule
